sc_fifo: RTL and testbench
==========================

# sc_fifo

Parametrised single-clock FIFO with integrated storage, registered status flags, programmable almost-full/almost-empty thresholds, sticky overflow/underflow flags and a selectable normal/show-ahead read mode. It is the single-clock successor of the dual-clock pointer/flag logic in our FIFO family. It serves same-domain buffering between pipeline stages. Unlike the dual-clock write side, it reports the full occupancy range 0..2**AWIDTH.

## Interface
- `DWIDTH`, 8: data word width.
- `AWIDTH`, 4: address width; depth is 2**AWIDTH words. Must be >= 1.
- `MODE`, `FIFO_NORMAL`: `fifo_pkg::fifo_mode_e`; `FIFO_NORMAL` or `FIFO_SHOWAHEAD`.
- `ALMOST_FULL_VALUE`, 12: almost-full threshold, in words.
- `ALMOST_EMPTY_VALUE`, 4: almost-empty threshold, in words. Legal range: 1 <= `ALMOST_EMPTY_VALUE` <= `ALMOST_FULL_VALUE` <= 2**AWIDTH. Checked at elaboration with `$error`.
- `clk_i` in, 1: the single clock.
- `srst_i` in, 1: synchronous, active-high reset.
- `data_i` in, DWIDTH: write data.
- `wrreq_i` in, 1: write request.
- `rdreq_i` in, 1: read request (normal mode) or read acknowledge/pop (show-ahead mode).
- `q_o` out, DWIDTH: read data.
- `empty_o` out, 1: FIFO holds 0 words.
- `full_o` out, 1: FIFO holds 2**AWIDTH words.
- `usedw_o` out, AWIDTH+1: occupancy in words, 0..2**AWIDTH.
- `almost_full_o` out, 1: `usedw_o` >= `ALMOST_FULL_VALUE`.
- `almost_empty_o` out, 1: `usedw_o` < `ALMOST_EMPTY_VALUE`.
- `ovf_o` out, 1: sticky; a write was attempted while full.
- `udf_o` out, 1: sticky; a read was attempted while empty.

## Operation
- **Accept rules**
  - Write accepted = `wrreq_i & ~full_o`.
  - Read accepted = `rdreq_i & ~empty_o`.
  - There is no write-through on full, even when a read is accepted in the same cycle.
- **Pointers**: write and read pointers are AWIDTH+1 bits binary; the MSB is the wrap bit. The low AWIDTH bits address storage. Each pointer increments by 1 per accepted operation and wraps naturally modulo 2**(AWIDTH+1).
- **Occupancy**: `usedw_o` is a registered counter.
  - +1 on write-only, −1 on read-only.
  - Unchanged on simultaneous accepted write and read, or on no accepted operation.
- **Flags**: `empty_o`, `full_o`, `almost_*_o` are registered. Each is computed from the next-state occupancy, so all flags are consistent with `usedw_o` in every cycle.
- **Rejected requests**: a rejected write or read leaves pointers, storage, `usedw_o` and `q_o` unchanged.
  - A rejected write sets `ovf_o`; a rejected read sets `udf_o`.
  - Both sticky flags clear only on `srst_i`.
- **`FIFO_NORMAL` mode**: `q_o` is a register loaded with the head word on the edge that accepts a read. It holds otherwise.
- **`FIFO_SHOWAHEAD` mode**: `q_o` = storage[rd_ptr] through an asynchronous read.
  - `q_o` is valid whenever `empty_o` = 0; it is don't-care while `empty_o` = 1.
  - An accepted read advances `q_o` to the next word in the following cycle.
- **Reset**: `srst_i` overrides all requests in the same cycle. On reset:
  - Pointers = 0, `usedw_o` = 0.
  - `empty_o` = 1, `full_o` = 0.
  - `almost_empty_o` = 1, `almost_full_o` = 0.
  - `ovf_o` = `udf_o` = 0.
  - `q_o` = 0 in normal mode.
  - Storage contents are not cleared.
  - A reset asserted mid-stream discards all queued words.

## Timing
- Write at edge N: `usedw_o`, `empty_o` = 0 and the threshold flags are visible after edge N. In show-ahead mode `q_o` is also valid after edge N.
- Normal-mode read latency: 1 cycle. Read accepted at edge N → `q_o` valid after edge N.
- Full at 2**AWIDTH: a write at edge N that brings occupancy to 2**AWIDTH makes `full_o` = 1 after edge N. A write at edge N+1 is rejected.
- Simultaneous write and read on a full FIFO: only the read is accepted. `full_o` drops after the edge and `ovf_o` sets.
- Simultaneous write and read on an empty FIFO: only the write is accepted. `udf_o` sets.
- `srst_i` sampled high at edge N: all outputs hold reset values after edge N. Requests at edge N are ignored.

## Structure
- `fifo_pkg`: `fifo_mode_e` typedef enum (`FIFO_NORMAL`, `FIFO_SHOWAHEAD`). Shared with the dual-clock FIFO family.
- Sub-module `fifo_mem` #(DWIDTH, AWIDTH): simple dual-port register array.
  - Synchronous write port.
  - Asynchronous read port.
  - No reset.
- Top level: pointers, occupancy counter, flag registers, sticky flags, mode-dependent `q_o` path, parameter checks.

## Test plan
All scenarios use DWIDTH=8, AWIDTH=4, AF=12, AE=4.
1. **Fill**: 16 writes 0x00..0x0F. `usedw_o` steps 1..16; `almost_empty_o` falls after the 4th write; `almost_full_o` rises after the 12th; `full_o` = 1 after the 16th. A 17th write sets `ovf_o`, leaves `usedw_o` = 16 and does not corrupt data.
2. **Normal drain**: 16 reads. `q_o` = 0x00..0x0F, each one cycle after its read. `empty_o` = 1 after the 16th read. A 17th read sets `udf_o` and `q_o` holds 0x0F.
3. **Show-ahead**: write 0xA5 into empty FIFO → `q_o` = 0xA5 with `empty_o` = 0 in the next cycle. Write 0x5A, pop once → `q_o` = 0x5A.
4. **Simultaneous operations**: at `usedw_o` = 8, 20 cycles of write+read → `usedw_o` stays 8, data order is preserved, and pointers wrap past 31→0 without error. On full, write+read → only the read is accepted and `ovf_o` = 1. On empty, write+read → only the write is accepted and `udf_o` = 1.
5. **Mid-stream reset**: `srst_i` for 1 cycle at `usedw_o` = 10 with `wrreq_i` = 1 → `usedw_o` = 0, `empty_o` = 1, `ovf_o`/`udf_o` = 0. The next write/read returns the newly written word.
6. **Thresholds**: AF=AE=16 → `almost_full_o` only at full; `almost_empty_o` is 1 for `usedw_o` 0..15.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO-family types: read-mode selection for single- and dual-clock FIFOs.
package fifo_pkg;

    typedef enum logic {
        FIFO_NORMAL    = 1'b0,
        FIFO_SHOWAHEAD = 1'b1
    } fifo_mode_e;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read, no reset.
// Latency: write visible on the read port after the write edge; read is combinational.
// Backpressure: none; the caller gates wr_en.
module fifo_mem #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [DWIDTH-1:0] rd_data
);

    logic [DWIDTH-1:0] mem [2**AWIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sc_fifo.sv
// Single-clock FIFO with registered occupancy/flags, sticky ovf/udf and normal/show-ahead read.
// Latency: flags and usedw one edge after the request; normal-mode q one edge after the read.
// Backpressure: writes are dropped while full, reads while empty; drops set the sticky flags.
module sc_fifo
    import fifo_pkg::*;
#(
    parameter int         DWIDTH             = 8,
    parameter int         AWIDTH             = 4,
    parameter fifo_mode_e MODE               = FIFO_NORMAL,
    parameter int         ALMOST_FULL_VALUE  = 12,
    parameter int         ALMOST_EMPTY_VALUE = 4
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              wrreq_i,
    input  logic              rdreq_i,
    output logic [DWIDTH-1:0] q_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [AWIDTH:0]   usedw_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic              ovf_o,
    output logic              udf_o
);

    localparam int              DEPTH   = 2**AWIDTH;
    localparam logic [AWIDTH:0] ONE     = (AWIDTH+1)'(1);
    localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH:0] AF_W    = (AWIDTH+1)'(ALMOST_FULL_VALUE);
    localparam logic [AWIDTH:0] AE_W    = (AWIDTH+1)'(ALMOST_EMPTY_VALUE);

    if (AWIDTH < 1) begin : g_chk_awidth
        $error("sc_fifo: AWIDTH must be >= 1");
    end
    if (ALMOST_EMPTY_VALUE < 1 || ALMOST_EMPTY_VALUE > ALMOST_FULL_VALUE ||
        ALMOST_FULL_VALUE > DEPTH) begin : g_chk_thresholds
        $error("sc_fifo: need 1 <= ALMOST_EMPTY_VALUE <= ALMOST_FULL_VALUE <= 2**AWIDTH");
    end

    logic [AWIDTH:0]   wr_ptr;
    logic [AWIDTH:0]   rd_ptr;
    logic [AWIDTH:0]   usedw_nxt;
    logic [DWIDTH-1:0] head;
    logic              wr_acc;
    logic              rd_acc;

    // Full blocks writes even when a read frees a slot in the same cycle.
    assign wr_acc = wrreq_i & ~full_o;
    assign rd_acc = rdreq_i & ~empty_o;

    always_comb begin
        usedw_nxt = usedw_o;
        case ({wr_acc, rd_acc})
            2'b10:   usedw_nxt = usedw_o + ONE;
            2'b01:   usedw_nxt = usedw_o - ONE;
            default: usedw_nxt = usedw_o;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            usedw_o        <= '0;
            empty_o        <= 1'b1;
            full_o         <= 1'b0;
            almost_empty_o <= 1'b1;
            almost_full_o  <= 1'b0;
            ovf_o          <= 1'b0;
            udf_o          <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + ONE;
            end
            // Flags derive from next-state occupancy so they never lag usedw_o.
            usedw_o        <= usedw_nxt;
            empty_o        <= (usedw_nxt == '0);
            full_o         <= (usedw_nxt == DEPTH_W);
            almost_full_o  <= (usedw_nxt >= AF_W);
            almost_empty_o <= (usedw_nxt < AE_W);
            if (wrreq_i & full_o) begin
                ovf_o <= 1'b1;
            end
            if (rdreq_i & empty_o) begin
                udf_o <= 1'b1;
            end
        end
    end

    fifo_mem #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_mem (
        .clk     (clk_i),
        .wr_en   (wr_acc & ~srst_i),
        .wr_addr (wr_ptr[AWIDTH-1:0]),
        .wr_data (data_i),
        .rd_addr (rd_ptr[AWIDTH-1:0]),
        .rd_data (head)
    );

    if (MODE == FIFO_SHOWAHEAD) begin : g_showahead
        assign q_o = head;
    end else begin : g_normal
        always_ff @(posedge clk_i) begin
            if (srst_i) begin
                q_o <= '0;
            end else if (rd_acc) begin
                q_o <= head;
            end
        end
    end

endmodule

// File: tb/tb_sc_fifo.sv
// Directed bench: normal, show-ahead and AF=AE=16 instances share one stimulus, checked against a queue model.
module tb_sc_fifo;
    import fifo_pkg::*;

    logic       clk = 1'b0;
    logic       srst = 1'b1;
    logic [7:0] data = '0;
    logic       wrreq = 1'b0;
    logic       rdreq = 1'b0;

    logic [7:0] n_q, s_q, t_q;
    logic       n_empty, n_full, n_af, n_ae, n_ovf, n_udf;
    logic       s_empty, s_full, s_af, s_ae, s_ovf, s_udf;
    logic       t_empty, t_full, t_af, t_ae, t_ovf, t_udf;
    logic [4:0] n_usedw, s_usedw, t_usedw;

    logic [7:0] exp_q[$];
    logic [7:0] m_qn;
    bit         m_ovf, m_udf;
    int         n_chk, n_pass;

    always #5 clk = ~clk;

    sc_fifo #(.DWIDTH(8), .AWIDTH(4), .MODE(FIFO_NORMAL),
              .ALMOST_FULL_VALUE(12), .ALMOST_EMPTY_VALUE(4)) u_norm (
        .clk_i(clk), .srst_i(srst), .data_i(data), .wrreq_i(wrreq), .rdreq_i(rdreq),
        .q_o(n_q), .empty_o(n_empty), .full_o(n_full), .usedw_o(n_usedw),
        .almost_full_o(n_af), .almost_empty_o(n_ae), .ovf_o(n_ovf), .udf_o(n_udf));

    sc_fifo #(.DWIDTH(8), .AWIDTH(4), .MODE(FIFO_SHOWAHEAD),
              .ALMOST_FULL_VALUE(12), .ALMOST_EMPTY_VALUE(4)) u_sa (
        .clk_i(clk), .srst_i(srst), .data_i(data), .wrreq_i(wrreq), .rdreq_i(rdreq),
        .q_o(s_q), .empty_o(s_empty), .full_o(s_full), .usedw_o(s_usedw),
        .almost_full_o(s_af), .almost_empty_o(s_ae), .ovf_o(s_ovf), .udf_o(s_udf));

    sc_fifo #(.DWIDTH(8), .AWIDTH(4), .MODE(FIFO_NORMAL),
              .ALMOST_FULL_VALUE(16), .ALMOST_EMPTY_VALUE(16)) u_thr (
        .clk_i(clk), .srst_i(srst), .data_i(data), .wrreq_i(wrreq), .rdreq_i(rdreq),
        .q_o(t_q), .empty_o(t_empty), .full_o(t_full), .usedw_o(t_usedw),
        .almost_full_o(t_af), .almost_empty_o(t_ae), .ovf_o(t_ovf), .udf_o(t_udf));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all();
        int used;
        used = exp_q.size();
        chk("n_usedw", 32'(n_usedw), 32'(used));
        chk("n_empty", 32'(n_empty), 32'(used == 0));
        chk("n_full",  32'(n_full),  32'(used == 16));
        chk("n_af",    32'(n_af),    32'(used >= 12));
        chk("n_ae",    32'(n_ae),    32'(used < 4));
        chk("n_ovf",   32'(n_ovf),   32'(m_ovf));
        chk("n_udf",   32'(n_udf),   32'(m_udf));
        chk("n_q",     32'(n_q),     32'(m_qn));
        chk("s_usedw", 32'(s_usedw), 32'(used));
        chk("s_empty", 32'(s_empty), 32'(used == 0));
        chk("s_ovf",   32'(s_ovf),   32'(m_ovf));
        chk("s_udf",   32'(s_udf),   32'(m_udf));
        if (used != 0) begin
            chk("s_q", 32'(s_q), 32'(exp_q[0]));
        end
        chk("t_af",    32'(t_af),    32'(used >= 16));
        chk("t_ae",    32'(t_ae),    32'(used < 16));
        chk("t_full",  32'(t_full),  32'(used == 16));
    endtask

    // One clock: drive requests, update the queue model from pre-edge state, check after the edge.
    task automatic cycle(input bit rst, input bit wr, input bit rd, input logic [7:0] din);
        int used;
        srst  = rst;
        wrreq = wr;
        rdreq = rd;
        data  = din;
        used  = exp_q.size();
        if (rst) begin
            exp_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            m_qn  = 8'h00;
        end else begin
            if (rd && used != 0)  m_qn = exp_q.pop_front();
            if (wr && used != 16) exp_q.push_back(din);
            if (wr && used == 16) m_ovf = 1'b1;
            if (rd && used == 0)  m_udf = 1'b1;
        end
        @(posedge clk);
        #1;
        srst  = 1'b0;
        wrreq = 1'b0;
        rdreq = 1'b0;
        check_all();
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        m_qn = 8'h00;
        m_ovf = 1'b0;
        m_udf = 1'b0;

        cycle(1, 0, 0, 8'h00);
        cycle(1, 0, 0, 8'h00);
        cycle(0, 0, 0, 8'h00);

        // Fill to full, then one rejected write.
        for (int i = 0; i < 16; i++) cycle(0, 1, 0, 8'(i));
        cycle(0, 1, 0, 8'h77);

        // Drain in order, then one rejected read (q holds 0x0F).
        for (int i = 0; i < 16; i++) cycle(0, 0, 1, 8'h00);
        cycle(0, 0, 1, 8'h00);
        cycle(0, 0, 0, 8'h00);

        // Show-ahead head visibility.
        cycle(0, 1, 0, 8'hA5);
        cycle(0, 1, 0, 8'h5A);
        cycle(0, 0, 1, 8'h00);
        cycle(0, 0, 1, 8'h00);

        // Steady state at 8 words with simultaneous ops; pointers wrap past 31.
        for (int i = 0; i < 8; i++) cycle(0, 1, 0, 8'h40 + 8'(i));
        for (int i = 0; i < 20; i++) cycle(0, 1, 1, 8'h80 + 8'(i));
        for (int i = 0; i < 8; i++) cycle(0, 1, 0, 8'hC0 + 8'(i));
        cycle(0, 1, 1, 8'hEE);
        cycle(0, 1, 0, 8'hD0);
        for (int i = 0; i < 16; i++) cycle(0, 0, 1, 8'h00);
        cycle(0, 1, 1, 8'h99);
        cycle(0, 0, 1, 8'h00);

        // Mid-stream reset with a write pending, then a fresh round trip.
        for (int i = 0; i < 10; i++) cycle(0, 1, 0, 8'h10 + 8'(i));
        cycle(1, 1, 0, 8'hEE);
        cycle(0, 1, 0, 8'h3C);
        cycle(0, 0, 1, 8'h00);
        cycle(0, 0, 0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
